encoder_n_queued: RTL

//  Parametrised N-to-log2(N) encoder with event queueing.
//  - Per-channel request pulses are captured into a sticky pending register.
//  - One pending channel at a time is encoded and presented on a valid/ready output.
//  - Two selection modes: fixed MSB-first priority, or round-robin.
//  - Sits between interrupt/event sources and a single downstream consumer that

---
 rtl/encoder_n_queued_if.sv | 34 +++
 rtl/encoder_n_queued.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/encoder_n_queued_if.sv
// Event-encoder bus: request side, encoded-code valid/ready side and status.
//   mode      master->slave  selection mode (0 fixed priority, 1 round-robin)
//   req       master->slave  per-channel one-cycle event pulses
//   ready     master->slave  consumer accepts code when valid && ready
//   clr_drop  master->slave  synchronous clear of drop_cnt
//   code      slave->master  encoded channel index
//   valid     slave->master  code holds a pending channel
//   pending   slave->master  sticky pending bits
//   drop_cnt  slave->master  saturating count of events lost to a pending channel
interface encoder_n_queued_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned DROP_W = 8
);
    localparam int unsigned W = $clog2(N);

    logic              mode;
    logic [N-1:0]      req;
    logic              ready;
    logic              clr_drop;
    logic [W-1:0]      code;
    logic              valid;
    logic [N-1:0]      pending;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output mode, req, ready, clr_drop,
        input  code, valid, pending, drop_cnt
    );

    modport slave (
        input  mode, req, ready, clr_drop,
        output code, valid, pending, drop_cnt
    );
endinterface

// File: rtl/encoder_n_queued.sv
// N-to-log2(N) encoder with sticky event queueing.
// Request pulses are latched into a pending register; one pending channel at a time is
// encoded and offered on a valid/ready handshake, chosen by fixed MSB-first priority or
// round-robin. Events arriving on an already-pending channel are counted as drops.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   bus     encoder_n_queued_if slave modport (mode, req, ready, clr_drop in;
//           code, valid, pending, drop_cnt out)
module encoder_n_queued #(
    parameter int unsigned N      = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    encoder_n_queued_if.slave    bus
);
    localparam int unsigned W    = $clog2(N);
    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned SumW = DROP_W + CntW;
    localparam logic [DROP_W-1:0] DropMax = '1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      code_q, code_d;
    logic [W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N-1:0]      pending_q, pending_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              accept;
    logic [N-1:0]      clr_mask;
    logic [N-1:0]      cand;
    logic [W-1:0]      rr_next;
    logic [W-1:0]      scan_ptr;
    logic [W-1:0]      rr_idx;
    logic [W-1:0]      sel_fixed;
    logic [W-1:0]      sel_rr;
    logic              rr_found;
    logic [W-1:0]      sel;
    logic [CntW-1:0]   drop_inc;
    logic [SumW-1:0]   drop_sum;

    assign accept  = (state_q == StHold) && bus.ready;
    assign rr_next = (code_q == W'(N - 1)) ? '0 : code_q + 1'b1;
    // On an accept the scan starts just past the channel being retired, so the pointer
    // used for the back-to-back load is the one being written this edge.
    assign scan_ptr = accept ? rr_next : rr_ptr_q;

    always_comb begin
        clr_mask = '0;
        if (accept) begin
            clr_mask[code_q] = 1'b1;
        end
    end

    assign pending_d = (pending_q & ~clr_mask) | bus.req;

    // Drops: a new event on a channel that is pending and not retired this cycle.
    always_comb begin
        drop_inc = '0;
        for (int k = 0; k < N; k++) begin
            drop_inc = drop_inc + CntW'(bus.req[k] & pending_q[k] & ~clr_mask[k]);
        end
        drop_sum = SumW'(drop_q) + SumW'(drop_inc);
        if (bus.clr_drop) begin
            drop_d = '0;
        end else if (drop_sum > SumW'(DropMax)) begin
            drop_d = DropMax;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    // Candidates exclude this cycle's req; a held code without accept loads nothing.
    always_comb begin
        cand = '0;
        if (state_q == StIdle) begin
            cand = pending_q;
        end else if (accept) begin
            cand = pending_q & ~clr_mask;
        end
    end

    always_comb begin
        sel_fixed = '0;
        for (int k = 0; k < N; k++) begin
            if (cand[k]) begin
                sel_fixed = W'(k);
            end
        end
    end

    always_comb begin
        sel_rr   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < N; i++) begin
            rr_idx = W'((int'(scan_ptr) + i) % N);
            if (!rr_found && cand[rr_idx]) begin
                sel_rr   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign sel = bus.mode ? sel_rr : sel_fixed;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (|cand) begin
                    code_d  = sel;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (accept) begin
                    rr_ptr_d = rr_next;
                    if (|cand) begin
                        code_d = sel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            code_q    <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.code     = code_q;
    assign bus.valid    = (state_q == StHold);
    assign bus.pending  = pending_q;
    assign bus.drop_cnt = drop_q;
endmodule
